// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: picks the next fetch address (redirect, branch-table
// prediction or sequential), issues in-order imem reads and queues returned instructions.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] bt_next_pc,
    output logic        bt_next_pc_valid,
    output logic [31:0] bt_if_pc,
    input  logic [31:0] bt_predicted_pc,
    input  logic        bt_use_prediction,
    input  logic        bt_prediction,
    input  logic        bt_flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] seq_pc_q, seq_pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        pred_window_q, pred_window_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic [1:0]  q_count_q, q_count_d;

    // Addresses of in-flight reads, popped in order as responses return.
    logic [31:0] afifo_q [2];
    logic [31:0] afifo_d [2];
    logic        afifo_wr_q, afifo_wr_d, afifo_rd_q, afifo_rd_d;

    logic [31:0] q_instr_q [2];
    logic [31:0] q_instr_d [2];
    logic [31:0] q_pc_q [2];
    logic [31:0] q_pc_d [2];
    logic        q_wr_q, q_wr_d, q_rd_q, q_rd_d;

    logic [31:0] cand;
    logic [2:0]  inflight;
    logic        issue, resp_drop, q_push, dec_pop;

    always_comb begin
        cand = seq_pc_q;
        if (bt_flush)
            cand = redirect_pc;
        else if (pred_window_q && bt_use_prediction && bt_prediction)
            cand = bt_predicted_pc;

        inflight  = {1'b0, outstanding_q} + {1'b0, q_count_q};
        imem_req  = (state_q == S_RUN) && !bt_flush && (inflight < 3'(FETCH_DEPTH));
        issue     = imem_req && imem_ack;
        resp_drop = imem_rvalid && (bt_flush || (drop_cnt_q != 2'd0));
        q_push    = imem_rvalid && !resp_drop;
        dec_valid = (q_count_q != 2'd0) && !bt_flush;
        dec_pop   = dec_valid && dec_ready;

        state_d       = S_RUN;
        // A stalled request keeps whatever target was chosen this cycle.
        seq_pc_d      = issue ? cand + 32'd4 : cand;
        if_pc_d       = issue ? cand : if_pc_q;
        pred_window_d = issue;
        outstanding_d = outstanding_q + 2'(issue) - 2'(imem_rvalid);

        afifo_d    = afifo_q;
        afifo_wr_d = afifo_wr_q ^ issue;
        afifo_rd_d = afifo_rd_q ^ imem_rvalid;
        if (issue)
            afifo_d[afifo_wr_q] = cand;

        drop_cnt_d = drop_cnt_q;
        if (bt_flush)
            drop_cnt_d = outstanding_q - 2'(imem_rvalid);
        else if (imem_rvalid && (drop_cnt_q != 2'd0))
            drop_cnt_d = drop_cnt_q - 2'd1;

        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        q_count_d = q_count_q;
        if (bt_flush) begin
            q_rd_d    = q_wr_q;
            q_count_d = 2'd0;
        end else begin
            if (q_push) begin
                q_instr_d[q_wr_q] = imem_rdata;
                q_pc_d[q_wr_q]    = afifo_q[afifo_rd_q];
                q_wr_d            = ~q_wr_q;
            end
            if (dec_pop)
                q_rd_d = ~q_rd_q;
            q_count_d = q_count_q + 2'(q_push) - 2'(dec_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            seq_pc_q      <= RESET_VEC;
            if_pc_q       <= RESET_VEC;
            pred_window_q <= 1'b0;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            q_count_q     <= 2'd0;
            afifo_wr_q    <= 1'b0;
            afifo_rd_q    <= 1'b0;
            q_wr_q        <= 1'b0;
            q_rd_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_pc_q      <= seq_pc_d;
            if_pc_q       <= if_pc_d;
            pred_window_q <= pred_window_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            q_count_q     <= q_count_d;
            afifo_wr_q    <= afifo_wr_d;
            afifo_rd_q    <= afifo_rd_d;
            q_wr_q        <= q_wr_d;
            q_rd_q        <= q_rd_d;
        end
    end

    // Storage only; validity is tracked by the reset-controlled pointers and counts.
    always_ff @(posedge clk) begin
        afifo_q   <= afifo_d;
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(q_push && !dec_pop && (q_count_q == 2'd2)));
    end

    assign bt_next_pc       = cand;
    assign imem_addr        = cand;
    assign bt_next_pc_valid = issue;
    assign bt_if_pc         = if_pc_q;
    assign dec_instr        = q_instr_q[q_rd_q];
    assign dec_pc           = q_pc_q[q_rd_q];

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end: the requesting side of the branch-table interface and the issuer of instruction-memory reads.
- Every cycle it drives the candidate fetch address to the branch table. It consumes the registered prediction one cycle later to pick the following address.
- It issues in-order reads to instruction memory and buffers returned instructions in a 2-entry queue toward decode.
- On a branch-unit flush it redirects, empties the queue and drops stale in-flight responses.

Parameters:
RESET_VEC, 32'h00000000, first fetch address after reset
FETCH_DEPTH, 2, combined outstanding-request plus queue capacity (fixed at 2 for this revision)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
bt_next_pc  output  32  candidate fetch address, driven every cycle (table read index)
bt_next_pc_valid  output  1  candidate issued this cycle
bt_if_pc  output  32  address of the most recently issued fetch
bt_predicted_pc  input  32  table target for bt_if_pc, valid the cycle after an issue
bt_use_prediction  input  1  table tag hit for bt_if_pc
bt_prediction  input  1  predicted taken
bt_flush  input  1  mispredict from execute
redirect_pc  input  32  correct PC, valid with bt_flush
imem_req  output  1  read request
imem_addr  output  32  read address (= bt_next_pc)
imem_ack  input  1  request accepted this cycle
imem_rvalid  input  1  read data return; in order, at least 1 cycle after accept
imem_rdata  input  32  instruction
dec_valid  output  1  queue head valid
dec_instr  output  32  head instruction
dec_pc  output  32  head PC
dec_ready  input  1  decode consumes head

Behaviour:
- Reset (sync): state=INIT; seq_pc=bt_if_pc=RESET_VEC; pred_window=0; outstanding=drop_cnt=q_count=0.
- Reset outputs: imem_req=0, bt_next_pc_valid=0, dec_valid=0.
- INIT lasts exactly 1 cycle, then RUN.
- Candidate (combinational), in priority order:
  - bt_flush → redirect_pc
  - else pred_window & bt_use_prediction & bt_prediction → bt_predicted_pc
  - else seq_pc
- bt_next_pc = imem_addr = candidate.
- Request rules:
  - imem_req = RUN & ~bt_flush & (outstanding + q_count < 2).
  - issue = imem_req & imem_ack; bt_next_pc_valid = issue.
  - On issue: bt_if_pc <= candidate; seq_pc <= candidate + 4 (mod 2^32, wraps); candidate pushed into the 2-entry address FIFO; outstanding++.
  - No issue: seq_pc <= candidate. This retains a prediction or redirect when the request is stalled.
- pred_window <= issue. The prediction is honoured only in the cycle directly after an issue.
- Response (imem_rvalid):
  - Pop the address FIFO; outstanding--.
  - If drop_cnt>0 or bt_flush in the same cycle: discard; drop_cnt-- (when drop_cnt>0).
  - Otherwise push {imem_rdata, popped address} into the queue.
  - Queue overflow is impossible by the capacity rule; assert on it.
- Flush cycle:
  - Queue cleared.
  - drop_cnt <= outstanding minus (1 if imem_rvalid this cycle).
  - dec_valid forced 0; no issue.
  - Redirected fetch issues earliest the next cycle (flush-to-req latency 1).
- Decode:
  - dec_valid = q_count>0 & ~bt_flush.
  - Pop on dec_valid & dec_ready.
  - Simultaneous push and pop keeps q_count unchanged.
  - Empty queue with arriving response: that response appears on dec outputs the following cycle (registered queue).
- Reset mid-operation: all counters, the queue and the FIFO clear. Instruction memory shares rst, so no pre-reset response returns.
- pred_window is cleared by flush (no issue occurs in the flush cycle).

Test Plan:
- Reset release, imem_ack=1, 1-cycle memory, dec_ready=1 → first req at 0x0 in the cycle after INIT; addresses 0x0, 0x4, 0x8…; dec_pc follows the same sequence.
- Issue 0x10; next cycle use_prediction=1, prediction=1, predicted_pc=0x40 → next imem_addr=0x40, then 0x44.
- Same as above, but imem_ack=0 for 3 cycles after the prediction cycle → imem_addr holds 0x40 throughout; issue at 0x40 when ack returns.
- Two requests outstanding (0x20, 0x24), bt_flush with redirect_pc=0x100 → both responses dropped; no dec_valid for them; next request 0x100 one cycle after flush.
- Flush coinciding with imem_rvalid for 0x20 while 0x24 is outstanding → drop_cnt=1; 0x24 response dropped; 0x100 delivered.
- dec_ready=0 → at most 2 requests in flight or queued; imem_req low until dec_ready=1 pops; dec_pc order preserved; seq_pc=0xFFFFFFFC wraps to 0x0.
